// File: rtl/ft_tx_packetizer.sv
// FFT-bin packetizer for the FT2232H synchronous-FIFO TX port: buffers bins as 64-bit frames
// and streams each frame as 8 bytes MSB first, stalling on TXE#.
module ft_tx_packetizer #(
  parameter int          CTR_WIDTH    = 10,
  parameter int          SAMPLE_WIDTH = 25,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [3:0]  SYNC_NIBBLE  = 4'hF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          bin_valid_i,
  input  logic [CTR_WIDTH-1:0]          bin_ctr_i,
  input  logic [SAMPLE_WIDTH-1:0]       bin_re_i,
  input  logic [SAMPLE_WIDTH-1:0]       bin_im_i,
  input  logic                          ft_txe_n_i,
  output logic [7:0]                    ft_data_o,
  output logic                          ft_wr_n_o,
  output logic                          ft_rd_n_o,
  output logic                          ft_oe_n_o,
  output logic                          ft_siwua_n_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic                          dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  generate
    if (4 + CTR_WIDTH + 2 * SAMPLE_WIDTH != 64) begin : g_bad_frame_width
      $error("ft_tx_packetizer: 4+CTR_WIDTH+2*SAMPLE_WIDTH must equal 64");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [63:0] frame_q, frame_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  data_q, data_d;
  logic        wr_n_q, wr_n_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [63:0] mem_q [FIFO_DEPTH];

  logic [63:0] in_frame;
  logic [63:0] head;
  logic [AW:0] level;
  logic        empty, full, push, pop, accept;

  function automatic logic [7:0] byte_of(input logic [63:0] frame, input logic [2:0] idx);
    return frame[(7 - int'(idx)) * 8 +: 8];
  endfunction

  assign in_frame = {SYNC_NIBBLE, bin_ctr_i, bin_re_i, bin_im_i};
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign push     = bin_valid_i && !full;
  assign accept   = !wr_n_q && !ft_txe_n_i;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    wr_n_d     = wr_n_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        wr_n_d = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          frame_d    = head;
          byte_idx_d = 3'd0;
          data_d     = byte_of(head, 3'd0);
          wr_n_d     = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (byte_idx_q != 3'd7) begin
            byte_idx_d = byte_idx_q + 3'd1;
            data_d     = byte_of(frame_q, byte_idx_q + 3'd1);
          end else if (!empty) begin
            // Back-to-back: next frame's byte0 follows byte7 with no idle cycle.
            pop        = 1'b1;
            frame_d    = head;
            byte_idx_d = 3'd0;
            data_d     = byte_of(head, 3'd0);
          end else begin
            byte_idx_d = 3'd0;
            wr_n_d     = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        wr_n_d  = 1'b1;
      end
    endcase
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    // A drop while full is sticky even if a pop frees a slot in the same cycle.
    ovf_d    = ovf_q || (bin_valid_i && full);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      byte_idx_q <= '0;
      data_q     <= '0;
      wr_n_q     <= 1'b1;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      byte_idx_q <= byte_idx_d;
      data_q     <= data_d;
      wr_n_q     <= wr_n_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_frame;
    end
  end

  assign ft_data_o    = data_q;
  assign ft_wr_n_o    = wr_n_q;
  assign ft_rd_n_o    = 1'b1;
  assign ft_oe_n_o    = 1'b1;
  assign ft_siwua_n_o = 1'b1;
  assign fifo_level_o = level;
  assign busy_o       = (state_q == SEND);
  assign overflow_o   = ovf_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ft_tx_packetizer.sv
// Bench for ft_tx_packetizer: drives bins and TXE#, predicts the byte stream from the frame
// layout table, and compares every accepted byte plus status outputs.
module tb_ft_tx_packetizer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        bin_valid;
  logic [9:0]  bin_ctr;
  logic [24:0] bin_re;
  logic [24:0] bin_im;
  logic        ft_txe_n;
  logic [7:0]  ft_data;
  logic        ft_wr_n, ft_rd_n, ft_oe_n, ft_siwua_n;
  logic [4:0]  fifo_level;
  logic        busy, overflow, dbg_state;

  ft_tx_packetizer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bin_valid_i  (bin_valid),
    .bin_ctr_i    (bin_ctr),
    .bin_re_i     (bin_re),
    .bin_im_i     (bin_im),
    .ft_txe_n_i   (ft_txe_n),
    .ft_data_o    (ft_data),
    .ft_wr_n_o    (ft_wr_n),
    .ft_rd_n_o    (ft_rd_n),
    .ft_oe_n_o    (ft_oe_n),
    .ft_siwua_n_o (ft_siwua_n),
    .fifo_level_o (fifo_level),
    .busy_o       (busy),
    .overflow_o   (overflow),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cnt, wr_low_cnt, hold_cnt, first_acc, last_acc;
  logic [7:0] exp_q[$];

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Expected byte stream straight from the frame layout table.
  task automatic add_frame(input logic [9:0] c, input logic [24:0] r, input logic [24:0] i);
    exp_q.push_back({4'hF, c[9:6]});
    exp_q.push_back({c[5:0], r[24:23]});
    exp_q.push_back(r[22:15]);
    exp_q.push_back(r[14:7]);
    exp_q.push_back({r[6:0], i[24]});
    exp_q.push_back(i[23:16]);
    exp_q.push_back(i[15:8]);
    exp_q.push_back(i[7:0]);
  endtask

  // Sampled at negedge: a byte presented now with TXE# low is taken at the next posedge.
  task automatic monitor();
    if (ft_wr_n === 1'b0) begin
      wr_low_cnt++;
      if (ft_txe_n === 1'b0) begin
        if (exp_q.size() == 0) check_eq("extra_byte_queue_size", 64'(exp_q.size()), 64'd1);
        else check_eq("byte", {56'd0, ft_data}, {56'd0, exp_q.pop_front()});
        if (acc_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
      end else begin
        hold_cnt++;
        if (exp_q.size() > 0) check_eq("hold_byte", {56'd0, ft_data}, {56'd0, exp_q[0]});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_bin(input logic [9:0] c, input logic [24:0] r, input logic [24:0] i,
                          input bit accepted);
    bin_ctr   = c;
    bin_re    = r;
    bin_im    = i;
    bin_valid = 1'b1;
    if (accepted) add_frame(c, r, i);
    tick();
    bin_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_txe);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      ft_txe_n = rand_txe ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick();
      guard++;
    end
    ft_txe_n = 1'b0;
    tick();
    tick();
    check_eq("drain_remaining", 64'(exp_q.size()), 64'd0);
    check_eq("idle_wr_n", {63'd0, ft_wr_n}, 64'd1);
    check_eq("idle_busy", {63'd0, busy}, 64'd0);
    check_eq("idle_level", {59'd0, fifo_level}, 64'd0);
  endtask

  task automatic clear_counts();
    acc_cnt = 0; wr_low_cnt = 0; hold_cnt = 0; first_acc = 0; last_acc = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, gap, guard;
    rst = 1'b1; bin_valid = 1'b0; bin_ctr = '0; bin_re = '0; bin_im = '0; ft_txe_n = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wr_n", {63'd0, ft_wr_n}, 64'd1);
    check_eq("rst_data", {56'd0, ft_data}, 64'd0);
    check_eq("rst_level", {59'd0, fifo_level}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_overflow", {63'd0, overflow}, 64'd0);
    check_eq("rst_state", {63'd0, dbg_state}, 64'd0);
    check_eq("tied_high", {61'd0, ft_rd_n, ft_oe_n, ft_siwua_n}, 64'd7);
    rst = 1'b0;
    tick();

    // T1: single bin, latency and exact byte stream
    ft_txe_n = 1'b0;
    clear_counts();
    push_bin(10'h2A5, 25'h1ABCDEF, 25'h0123456, 1'b1);
    check_eq("t1_wr_n_at_e0", {63'd0, ft_wr_n}, 64'd1);
    tick();
    check_eq("t1_wr_n_at_e1", {63'd0, ft_wr_n}, 64'd0);
    check_eq("t1_byte0", {56'd0, ft_data}, 64'hFA);
    check_eq("t1_busy", {63'd0, busy}, 64'd1);
    drain(1'b0);
    check_eq("t1_wr_low_cycles", 64'(wr_low_cnt), 64'd8);
    check_eq("t1_bytes", 64'(acc_cnt), 64'd8);

    // T2: stall for 5 cycles after byte2
    clear_counts();
    push_bin(10'h2A5, 25'h1ABCDEF, 25'h0123456, 1'b1);
    guard = 0;
    while (acc_cnt < 3 && guard < 50) begin tick(); guard++; end
    check_eq("t2_reach_byte2", 64'(acc_cnt), 64'd3);
    ft_txe_n = 1'b1;
    repeat (5) tick();
    ft_txe_n = 1'b0;
    drain(1'b0);
    check_eq("t2_hold_cycles", 64'(hold_cnt), 64'd5);
    check_eq("t2_bytes", 64'(acc_cnt), 64'd8);

    // T3: three bins back to back, contiguous 24 writes
    clear_counts();
    for (int k = 0; k < 3; k++) push_bin(10'(k + 100), 25'($urandom), 25'($urandom), 1'b1);
    drain(1'b0);
    check_eq("t3_bytes", 64'(acc_cnt), 64'd24);
    check_eq("t3_wr_low_cycles", 64'(wr_low_cnt), 64'd24);
    check_eq("t3_contiguous", 64'(last_acc - first_acc), 64'd23);

    // T6: 2*DEPTH bins through the wrap boundary
    clear_counts();
    for (int k = 0; k < 2 * DEPTH; k++) begin
      push_bin(10'(k), 25'($urandom), 25'($urandom), 1'b1);
      repeat (5) tick();
    end
    drain(1'b0);
    check_eq("t6_bytes", 64'(acc_cnt), 64'(16 * DEPTH));
    check_eq("t6_overflow", {63'd0, overflow}, 64'd0);

    // Random rounds: bursts no larger than the buffer, random TXE#
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin
        ft_txe_n = ($urandom_range(0, 2) == 0);
        push_bin(10'($urandom_range(0, 1023)), 25'($urandom), 25'($urandom), 1'b1);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          ft_txe_n = ($urandom_range(0, 2) == 0);
          tick();
        end
      end
      drain(1'b1);
    end
    check_eq("rand_overflow", {63'd0, overflow}, 64'd0);

    // T4: TXE# high; one frame sits in the output register, DEPTH more fill the buffer
    ft_txe_n = 1'b1;
    clear_counts();
    for (int k = 0; k < DEPTH + 2; k++) begin
      push_bin(10'(k), 25'($urandom), 25'($urandom), k < DEPTH + 1);
      if (k == DEPTH) begin
        check_eq("t4_level_full", {59'd0, fifo_level}, 64'(DEPTH));
        check_eq("t4_no_overflow_yet", {63'd0, overflow}, 64'd0);
      end
    end
    check_eq("t4_level_after_drop", {59'd0, fifo_level}, 64'(DEPTH));
    check_eq("t4_overflow", {63'd0, overflow}, 64'd1);
    drain(1'b0);
    check_eq("t4_bytes", 64'(acc_cnt), 64'(8 * (DEPTH + 1)));
    check_eq("t4_overflow_sticky", {63'd0, overflow}, 64'd1);

    // T5: reset while byte4 is presented
    ft_txe_n = 1'b1;
    clear_counts();
    push_bin(10'h155, 25'h0F0F0F0, 25'h1234567, 1'b1);
    tick();
    ft_txe_n = 1'b0;
    repeat (4) tick();
    ft_txe_n = 1'b1;
    check_eq("t5_byte4_presented", {56'd0, ft_data}, {56'd0, exp_q[0]});
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_wr_n", {63'd0, ft_wr_n}, 64'd1);
    check_eq("t5_rst_level", {59'd0, fifo_level}, 64'd0);
    check_eq("t5_rst_overflow", {63'd0, overflow}, 64'd0);
    check_eq("t5_rst_state", {63'd0, dbg_state}, 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    ft_txe_n = 1'b0;
    tick();
    clear_counts();
    push_bin(10'h3C3, 25'($urandom), 25'($urandom), 1'b1);
    drain(1'b0);
    check_eq("t5_new_frame_bytes", 64'(acc_cnt), 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
